// File: rtl/axi_write_data_steer.sv
// axi_write_data_steer
//   W-channel companion to the AXI write-request arbiter. Each AW grant
//   ({input index, AWLEN}) is recorded in a small order queue. W beats from
//   the granted slave are then steered onto the single master W channel in
//   AW-grant order, one whole burst at a time. WLAST is regenerated from
//   AWLEN, and any slave whose own WLAST disagrees sets a sticky error flag.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   aw_valid_in / aw_ready_out  AW grant push handshake into the order queue
//   aw_sel_in, aw_len_in        granted input index and AWLEN (beats-1)
//   s_wvalid/s_wready           per-slave W handshake (one bit per slave)
//   s_wdata/s_wstrb/s_wlast     per-slave W payload, slave i in slice i
//   m_axi_w*                    master W channel (wlast regenerated)
//   wlast_err                   sticky slave-WLAST mismatch flag
module axi_write_data_steer #(
    parameter int NUM_INPUTS     = 2,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int ORDER_DEPTH    = 4,
    parameter int SEL_W          = $clog2(NUM_INPUTS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  aw_valid_in,
    output logic                                  aw_ready_out,
    input  logic [SEL_W-1:0]                      aw_sel_in,
    input  logic [7:0]                            aw_len_in,
    input  logic [NUM_INPUTS-1:0]                 s_wvalid,
    output logic [NUM_INPUTS-1:0]                 s_wready,
    input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0]  s_wdata,
    input  logic [NUM_INPUTS*AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [NUM_INPUTS-1:0]                 s_wlast,
    output logic                                  m_axi_wvalid,
    input  logic                                  m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]             m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]           m_axi_wstrb,
    output logic                                  m_axi_wlast,
    output logic                                  wlast_err
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(ORDER_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [SEL_W-1:0] q_sel [ORDER_DEPTH];
    logic [7:0]       q_len [ORDER_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [SEL_W-1:0] cur_sel;
    logic [7:0]       beats_left;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             fire;
    logic             sel_wlast;

    // Fullness comes only from the registered count, so a pop in the same
    // cycle never frees a slot for a simultaneous push, and a fresh entry is
    // never visible to the FSM before the following cycle.
    assign full         = (count == CNT_W'(ORDER_DEPTH));
    assign empty        = (count == '0);
    assign aw_ready_out = !full && !reset;
    assign push         = aw_valid_in && aw_ready_out;
    assign fire         = m_axi_wvalid && m_axi_wready;

    // Combinational steering of the selected slave onto the master channel.
    // Handshakes are only opened in BURST and are forced closed during reset.
    always_comb begin
        m_axi_wvalid = 1'b0;
        s_wready     = '0;
        m_axi_wdata  = '0;
        m_axi_wstrb  = '0;
        sel_wlast    = 1'b0;
        m_axi_wlast  = (beats_left == 8'd0);
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                m_axi_wdata = s_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                m_axi_wstrb = s_wstrb[i*STRB_W +: STRB_W];
                sel_wlast   = s_wlast[i];
                if (state == BURST && !reset) begin
                    m_axi_wvalid = s_wvalid[i];
                    s_wready[i]  = m_axi_wready;
                end
            end
        end
    end

    // Next-state logic. The final beat of a burst pops the next queued grant
    // directly so consecutive bursts run without an idle cycle between them.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (fire && beats_left == 8'd0) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, order queue, beat counter and sticky WLAST check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            cur_sel    <= '0;
            beats_left <= '0;
            wlast_err  <= 1'b0;
        end else begin
            state <= state_next;

            if (push) begin
                q_sel[wr_ptr] <= aw_sel_in;
                q_len[wr_ptr] <= aw_len_in;
                wr_ptr        <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                cur_sel    <= q_sel[rd_ptr];
                beats_left <= q_len[rd_ptr];
            end else if (fire && beats_left != 8'd0) begin
                beats_left <= beats_left - 8'd1;
            end

            if (fire && (sel_wlast != m_axi_wlast)) begin
                wlast_err <= 1'b1;
            end
        end
    end

endmodule
